// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: MemOp encodings, FSM states, counter width.
package dmem_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_HS) || (op == OP_HU);
  endfunction

  function automatic logic is_byte(input logic [2:0] op);
    return (op == OP_BS) || (op == OP_BU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts/extends load data and builds the byte-enabled store word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] wword_o,
  output logic [3:0]  be_o
);

  logic [31:0] shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] rep;

  always_comb begin
    shifted  = word_i >> {addr_i, 3'b000};
    sel_byte = shifted[7:0];
    sel_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    rep      = wdata_i;
    be_o     = 4'hF;
    case (op_i)
      OP_HS: begin
        load_o = {{16{sel_half[15]}}, sel_half};
        rep    = {2{wdata_i[15:0]}};
        be_o   = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      OP_HU: begin
        load_o = {16'h0000, sel_half};
        rep    = {2{wdata_i[15:0]}};
        be_o   = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      OP_BS: begin
        load_o = {{24{sel_byte[7]}}, sel_byte};
        rep    = {4{wdata_i[7:0]}};
        be_o   = 4'b0001 << addr_i;
      end
      OP_BU: begin
        load_o = {24'h000000, sel_byte};
        rep    = {4{wdata_i[7:0]}};
        be_o   = 4'b0001 << addr_i;
      end
      default: begin
        load_o = word_i;
        rep    = wdata_i;
        be_o   = 4'hF;
      end
    endcase
    // Unselected lanes keep the old RAM contents so the merged word is writable as a whole.
    for (int i = 0; i < 4; i++) begin
      wword_o[8*i +: 8] = be_o[i] ? rep[8*i +: 8] : word_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// Multi-cycle MEM-stage data RAM with byte/half/word access and pipeline stall.
// Optional misalignment detection is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// Handshake: a request (MemR|MemW) is accepted on the first rising edge seen in IDLE;
// DmStall is high from that request cycle until the access reaches DONE, where DmValid
// pulses for one cycle. The requester must drop MemR/MemW once DmStall falls.
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemR,
  input  logic              MemW,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [31:0]       DmIn,
  output logic [31:0]       DmOut,
  output logic              DmValid,
  output logic              DmStall,
  output logic              DmErr,
  output dmem_state_e       dbg_state_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  logic [31:0] mem_q [0:DEPTH-1];

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        op_q;
  logic              wr_q;
  logic [31:0]       dout_q;
  logic              valid_q;
  logic              err_q;

  logic              req;
  logic              in_idle;
  logic              enter_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [2:0]        cur_op;
  logic              cur_wr;
  logic              misalign;
  logic [31:0]       rd_word;
  logic [31:0]       load_val;
  logic [31:0]       wword;
  logic [3:0]        be;

  assign req     = MemR | MemW;
  assign in_idle = (state_q == ST_IDLE);

  // With WAIT_CYCLES=0 the access completes straight from IDLE, before anything is latched.
  assign cur_addr  = in_idle ? DmAddr : addr_q;
  assign cur_wdata = in_idle ? DmIn   : wdata_q;
  assign cur_op    = in_idle ? MemOp  : op_q;
  assign cur_wr    = in_idle ? MemW   : wr_q;

  assign rd_word = mem_q[cur_addr[ADDR_W-1:2]];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = is_half(cur_op) ? cur_addr[0]
                  : (is_byte(cur_op) ? 1'b0 : (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  dmem_lane_align u_align (
    .word_i  (rd_word),
    .addr_i  (cur_addr[1:0]),
    .op_i    (cur_op),
    .wdata_i (cur_wdata),
    .load_o  (load_val),
    .wword_o (wword),
    .be_o    (be)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_done = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_W;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= enter_done;
      err_q   <= enter_done && misalign;
      if (in_idle && req) begin
        addr_q  <= DmAddr;
        wdata_q <= DmIn;
        op_q    <= MemOp;
        wr_q    <= MemW;
      end
      if (enter_done && !cur_wr && !misalign) dout_q <= load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_done && cur_wr && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[cur_addr[ADDR_W-1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign DmStall     = !rst && ((in_idle && req) || (state_q == ST_BUSY));
  assign DmOut       = dout_q;
  assign DmValid     = valid_q;
  assign DmErr       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: vector table through a scoreboard queue plus reset/abort sequences.
module tb_dmem_stage;
  import dmem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int WAIT   = 2;

  logic              clk;
  logic              rst;
  logic              MemR;
  logic              MemW;
  logic [2:0]        MemOp;
  logic [ADDR_W-1:0] DmAddr;
  logic [31:0]       DmIn;
  logic [31:0]       DmOut;
  logic              DmValid;
  logic              DmStall;
  logic              DmErr;
  dmem_state_e       dbg_state;

  dmem_stage #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemR        (MemR),
    .MemW        (MemW),
    .MemOp       (MemOp),
    .DmAddr      (DmAddr),
    .DmIn        (DmIn),
    .DmOut       (DmOut),
    .DmValid     (DmValid),
    .DmStall     (DmStall),
    .DmErr       (DmErr),
    .dbg_state_o (dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              rd;
    logic              wr;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              perturb;
    logic [31:0]       exp_out;
    logic              exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_load;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rd, input logic wr, input logic [2:0] op,
                              input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                              input logic perturb, input logic [31:0] exp_out, input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.data = data;
    v.perturb = perturb; v.exp_out = exp_out; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // driver: one complete access, checking stall length, completion latency and result
  task automatic run_access(input vec_t v, input int idx);
    int    stall_n;
    bit    seen;
    string tag;
    logic [31:0] exp;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    MemR = v.rd; MemW = v.wr; MemOp = v.op; DmAddr = v.addr; DmIn = v.data;
    if (v.wr || v.exp_err) exp_q.push_back(last_load);
    else begin
      exp_q.push_back(v.exp_out);
      last_load = v.exp_out;
    end
    stall_n = 0;
    seen    = 0;
    #1;
    if (DmStall) stall_n++;
    @(posedge clk);
    #1;
    MemR = 1'b0; MemW = 1'b0;
    if (v.perturb) begin
      DmAddr = v.addr ^ 10'h004;
      DmIn   = ~v.data;
      MemOp  = OP_BU;
    end
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (DmStall) stall_n++;
      if (DmValid) begin
        seen = 1;
        check({tag, " valid_latency"}, cyc, WAIT + 1);
        exp = exp_q.pop_front();
        check({tag, " dmout"}, DmOut, exp);
        check({tag, " dmerr"}, {31'b0, DmErr}, {31'b0, v.exp_err});
      end
    end
    if (!seen) begin
      check({tag, " valid_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check({tag, " stall_cycles"}, stall_n, WAIT + 1);
    @(negedge clk);
    check({tag, " valid_pulse_end"}, {31'b0, DmValid}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; last_load = 32'h0;
    MemR = 1'b0; MemW = 1'b0; MemOp = OP_W; DmAddr = '0; DmIn = '0;

    //    rd wr  op     addr    data          pt  exp_out       err
    add(0, 1, OP_W,  10'h010, 32'hDEADBEEF, 0, 32'h0,        0);
    add(1, 0, OP_W,  10'h010, 32'h0,         0, 32'hDEADBEEF, 0);
    add(0, 1, OP_BS, 10'h013, 32'h00000080, 0, 32'h0,        0);
    add(1, 0, OP_BS, 10'h013, 32'h0,         0, 32'hFFFFFF80, 0);
    add(1, 0, OP_BU, 10'h013, 32'h0,         0, 32'h00000080, 0);
    add(1, 0, OP_W,  10'h010, 32'h0,         0, 32'h80ADBEEF, 0);
    add(0, 1, OP_HS, 10'h012, 32'h00001234, 0, 32'h0,        0);
    add(1, 0, OP_HU, 10'h012, 32'h0,         0, 32'h00001234, 0);
    add(1, 0, OP_HS, 10'h010, 32'h0,         0, 32'hFFFFBEEF, 0);
    add(1, 0, OP_HU, 10'h010, 32'h0,         0, 32'h0000BEEF, 0);
    add(1, 0, OP_BS, 10'h010, 32'h0,         0, 32'hFFFFFFEF, 0);
    add(1, 0, OP_BU, 10'h011, 32'h0,         0, 32'h000000BE, 0);
    add(0, 1, 3'b111, 10'h040, 32'hCAFE8001, 0, 32'h0,       0);
    add(1, 0, 3'b101, 10'h040, 32'h0,        0, 32'hCAFE8001, 0);
    add(0, 1, OP_HU, 10'h040, 32'hFFFF7F01, 0, 32'h0,        0);
    add(1, 0, OP_W,  10'h040, 32'h0,         0, 32'hCAFE7F01, 0);
    add(1, 0, OP_HS, 10'h042, 32'h0,         0, 32'hFFFFCAFE, 0);
    add(1, 1, OP_W,  10'h080, 32'h0BADF00D, 0, 32'h0,        0); // both high acts as store
    add(1, 0, OP_W,  10'h080, 32'h0,         0, 32'h0BADF00D, 0);
    add(0, 1, OP_BU, 10'h3FF, 32'hFFFFFFA5, 0, 32'h0,        0);
    add(1, 0, OP_BU, 10'h3FF, 32'h0,         0, 32'h000000A5, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    add(1, 0, OP_W,  10'h011, 32'h0,         0, 32'h0,        1);
    add(0, 1, OP_W,  10'h012, 32'h99999999, 0, 32'h0,        1);
    add(1, 0, OP_W,  10'h010, 32'h0,         0, 32'h1234BEEF, 0);
`else
    add(1, 0, OP_W,  10'h011, 32'h0,         0, 32'h1234BEEF, 0);
    add(0, 1, OP_W,  10'h012, 32'h99999999, 0, 32'h0,        0);
    add(1, 0, OP_W,  10'h010, 32'h0,         0, 32'h99999999, 0);
`endif
    add(0, 1, OP_W,  10'h064, 32'h01010101, 0, 32'h0,        0);
    add(0, 1, OP_W,  10'h060, 32'h5A5A5A5A, 1, 32'h0,        0);
    add(1, 0, OP_W,  10'h060, 32'h0,         1, 32'h5A5A5A5A, 0);
    add(1, 0, OP_W,  10'h064, 32'h0,         0, 32'h01010101, 0);
    add(0, 1, OP_W,  10'h020, 32'h11223344, 0, 32'h0,        0);
    add(1, 0, OP_W,  10'h020, 32'h0,         0, 32'h11223344, 0);

    // reset held two cycles with a pending load: no stall, outputs at reset values
    rst = 1'b1; MemR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_stall", {31'b0, DmStall}, 32'd0);
    end
    check("rst_dmout", DmOut, 32'h0);
    check("rst_valid", {31'b0, DmValid}, 32'd0);
    check("rst_err", {31'b0, DmErr}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b0; MemR = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_access(vecs[i], i);

    // abort: reset lands while a store is in BUSY
    @(negedge clk);
    MemW = 1'b1; MemOp = OP_W; DmAddr = 10'h020; DmIn = 32'h00000055;
    @(posedge clk);
    #1;
    MemW = 1'b0;
    @(negedge clk);
    check("abort_busy", {30'b0, dbg_state}, {30'b0, ST_BUSY});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_dmout", DmOut, 32'h0);
    check("abort_stall", {31'b0, DmStall}, 32'd0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        if (DmValid) pulses++;
        @(negedge clk);
      end
      check("abort_no_valid", pulses, 0);
    end
    last_load = 32'h0;
    begin
      vec_t v;
      v.rd = 1; v.wr = 0; v.op = OP_W; v.addr = 10'h020; v.data = 32'h0;
      v.perturb = 0; v.exp_out = 32'h11223344; v.exp_err = 0;
      run_access(v, 100);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
